alu_mc: RTL and testbench
=========================

// Module: alu_mc
// PURPOSE
//  Parametrised multi-cycle ALU for the execute stage.
//  - Keeps the existing 4-bit op encoding for ADD/SUB/AND/OR/NOR/XOR/SLT.
//  - Adds shifts, SLTU, iterative MUL/MULHU/DIVU/REMU and a signed-overflow flag.
//  - Uses valid/ready handshakes so the pipeline stalls while an iterative op runs.
// PARAMETERS
//  WIDTH       32  operand/result width in bits (>=8, power of two)
//  MUL_DIV_EN  1   1: iterative mul/div ops enabled; 0: those opcodes decode as undefined
// PORTS
//  clk            in   1      single clock, all state updates on rising edge
//  rst            in   1      synchronous, active-high reset
//  in_valid       in   1      operands + op presented
//  in_ready       out  1      block can accept an op this cycle
//  oprd1          in   WIDTH  operand A
//  oprd2          in   WIDTH  operand B
//  ALU_Operation  in   4      opcode (see BEHAVIOUR)
//  out_valid      out  1      result/flags valid
//  out_ready      in   1      consumer takes result this cycle
//  result         out  WIDTH  registered result
//  zero           out  1      registered: result == 0
//  overflow       out  1      registered: signed overflow of ADD/SUB, else 0
//  busy           out  1      iterative op in progress (state BUSY)
// BEHAVIOUR
//  Opcodes:
//   0010 ADD | 0110 SUB | 0000 AND | 0001 OR | 1100 NOR | 1000 XOR
//   0111 SLT (signed) | 1001 SLTU | 0011 SLL | 0100 SRL | 0101 SRA
//   1010 MUL (low WIDTH) | 1011 MULHU (high WIDTH, unsigned)
//   1110 DIVU | 1111 REMU
//   Any other code: result 0, zero 1, overflow 0, single-cycle.
//  Shift amount = oprd2[$clog2(WIDTH)-1:0]; upper bits ignored.
//  Set ops (SLT/SLTU) return 1 or 0, zero-extended to WIDTH.
//  FSM states: IDLE, BUSY, DONE.
//  - IDLE: in_ready=1. Accept on in_valid&in_ready; operands and op are latched.
//    - Single-cycle op -> DONE; result valid the next cycle (latency 1).
//    - Iterative op -> BUSY; counter loaded with WIDTH.
//  - BUSY: in_ready=0, busy=1. One shift-add (MUL*) or restoring-divide (DIV*/REM*)
//    step per cycle. After WIDTH steps -> DONE. Total latency WIDTH+1 cycles.
//  - DONE: out_valid=1; result/zero/overflow held stable until out_ready.
//    out_valid&out_ready -> IDLE. in_ready=0 in DONE (no same-cycle accept).
//    Max throughput: one op per 2 cycles.
//  Input side: oprd1/oprd2/op may change freely after acceptance.
//  Divide by zero: DIVU -> all ones; REMU -> oprd1. Still takes WIDTH+1 cycles.
//  overflow: ADD when operand signs are equal and the result sign differs;
//   SUB when operand signs differ and the result sign differs from oprd1.
//  Wrap-around: ADD/SUB/MUL truncate to WIDTH; no exceptions raised.
//  MUL_DIV_EN=0: 1010/1011/1110/1111 behave as undefined opcodes; BUSY unreachable.
//  Reset values: state IDLE, in_ready=1 on the first cycle after reset; out_valid=0,
//   result=0, zero=0, overflow=0, busy=0, counter=0.
//  Reset mid-operation (BUSY or DONE): the op is dropped, no out_valid pulse,
//   and the block returns to the IDLE reset values on the next edge.
//  in_valid while in_ready=0: ignored, not queued; the source must hold it.
// TESTING
//  1. ADD 0x7FFFFFFF+1 -> out_valid 1 cycle after accept; result 0x80000000,
//     overflow 1, zero 0.
//  2. SUB 5-5 -> result 0, zero 1, overflow 0.
//     SLT 0xFFFFFFFF vs 1 -> result 1.
//     SLTU 0xFFFFFFFF vs 1 -> result 0.
//  3. SRA 0x80000000 by oprd2=0x24 -> shift 4; result 0xF8000000.
//     SLL 1 by 31 -> result 0x80000000.
//  4. MUL 0xFFFFFFFF*2 -> busy for 32 cycles, out_valid at cycle 33, result 0xFFFFFFFE.
//     MULHU of the same operands -> result 1.
//  5. DIVU 100/7 -> 14; REMU 100/7 -> 2.
//     DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9.
//  6. Hold out_ready=0 for 5 cycles in DONE -> result and in_ready=0 stay stable.
//     Assert rst during BUSY -> next cycle out_valid=0, in_ready=1, result=0.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU with valid/ready handshakes on both sides.
// Single-cycle ops answer one cycle after acceptance; MUL*/DIVU/REMU iterate WIDTH steps.
module alu_mc #(
    parameter int WIDTH      = 32,
    parameter bit MUL_DIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] oprd1,
    input  logic [WIDTH-1:0] oprd2,
    input  logic [3:0]       ALU_Operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLL   = 4'b0011;
    localparam logic [3:0] OP_SRL   = 4'b0100;
    localparam logic [3:0] OP_SRA   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_XOR   = 4'b1000;
    localparam logic [3:0] OP_SLTU  = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_DIVU  = 4'b1110;
    localparam logic [3:0] OP_REMU  = 4'b1111;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e               state_q, state_d;
    logic                 is_div_q;     // 0: shift-add multiply, 1: restoring divide
    logic                 hi_half_q;    // MULHU/REMU take the upper half of acc
    logic [WIDTH-1:0]     opb_q;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q;
    logic [WIDTH-1:0]     result_q;
    logic                 zero_q, overflow_q;

    logic                 iter_op;
    logic [SHW-1:0]       shamt;
    logic [WIDTH-1:0]     add_res, sub_res, alu_res, step_res;
    logic                 alu_ovf;
    logic [WIDTH:0]       mul_sum, rem_sh, div_diff;

    assign iter_op = MUL_DIV_EN && (ALU_Operation == OP_MUL  || ALU_Operation == OP_MULHU ||
                                    ALU_Operation == OP_DIVU || ALU_Operation == OP_REMU);
    assign shamt   = oprd2[SHW-1:0];
    assign add_res = oprd1 + oprd2;
    assign sub_res = oprd1 - oprd2;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (ALU_Operation)
            OP_ADD: begin
                alu_res = add_res;
                alu_ovf = (oprd1[WIDTH-1] == oprd2[WIDTH-1]) && (add_res[WIDTH-1] != oprd1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_res;
                alu_ovf = (oprd1[WIDTH-1] != oprd2[WIDTH-1]) && (sub_res[WIDTH-1] != oprd1[WIDTH-1]);
            end
            OP_AND:  alu_res = oprd1 & oprd2;
            OP_OR:   alu_res = oprd1 | oprd2;
            OP_NOR:  alu_res = ~(oprd1 | oprd2);
            OP_XOR:  alu_res = oprd1 ^ oprd2;
            OP_SLT:  alu_res = WIDTH'($signed(oprd1) < $signed(oprd2));
            OP_SLTU: alu_res = WIDTH'(oprd1 < oprd2);
            OP_SLL:  alu_res = oprd1 << shamt;
            OP_SRL:  alu_res = oprd1 >> shamt;
            OP_SRA:  alu_res = $signed(oprd1) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // acc holds {partial product, multiplier} or {remainder, quotient} as the op iterates.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = rem_sh - {1'b0, opb_q};
        if (!is_div_q)
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        else if (!div_diff[WIDTH])
            acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else
            acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        step_res = hi_half_q ? acc_d[2*WIDTH-1:WIDTH] : acc_d[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = iter_op ? S_BUSY : S_DONE;
            S_BUSY:  if (cnt_q == CW'(1)) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        busy      = (state_q == S_BUSY);
        out_valid = (state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_div_q   <= 1'b0;
            hi_half_q  <= 1'b0;
            opb_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    is_div_q  <= ALU_Operation[2];
                    hi_half_q <= ALU_Operation[0];
                    opb_q     <= oprd2;
                    acc_q     <= {{WIDTH{1'b0}}, oprd1};
                    if (iter_op) begin
                        cnt_q <= CW'(WIDTH);
                    end else begin
                        result_q   <= alu_res;
                        zero_q     <= (alu_res == '0);
                        overflow_q <= alu_ovf;
                    end
                end
                S_BUSY: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        result_q   <= step_res;
                        zero_q     <= (step_res == '0);
                        overflow_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result   = result_q;
    assign zero     = zero_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed corner cases plus random ops scored
// against an arithmetic reference model.
module tb_alu_mc;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, in_valid, out_ready;
    logic [W-1:0] oprd1, oprd2;
    logic [3:0]   alu_op;
    logic         in_ready, out_valid, zero, overflow, busy;
    logic [W-1:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    alu_mc #(.WIDTH(W), .MUL_DIV_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .oprd1(oprd1), .oprd2(oprd2), .ALU_Operation(alu_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: the opcode table evaluated with plain wide arithmetic.
    task automatic ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] r, output logic ovf, output int lat);
        logic [2*W-1:0] p;
        longint         s;
        r = '0; ovf = 1'b0; lat = 1;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (op)
            4'b0010: begin
                r = a + b;
                s = longint'($signed(a)) + longint'($signed(b));
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0110: begin
                r = a - b;
                s = longint'($signed(a)) - longint'($signed(b));
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b1100: r = ~(a | b);
            4'b1000: r = a ^ b;
            4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1001: r = (a < b) ? 32'd1 : 32'd0;
            4'b0011: r = a << b[4:0];
            4'b0100: r = a >> b[4:0];
            4'b0101: r = $signed(a) >>> b[4:0];
            4'b1010: begin r = p[W-1:0];   lat = W + 1; end
            4'b1011: begin r = p[2*W-1:W]; lat = W + 1; end
            4'b1110: begin r = (b == 0) ? '1 : a / b; lat = W + 1; end
            4'b1111: begin r = (b == 0) ? a  : a % b; lat = W + 1; end
            default: r = '0;
        endcase
    endtask

    // Issue one op, measure latency, check outputs, optionally stall the consumer.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold);
        logic [W-1:0] exp_r;
        logic         exp_ovf;
        int           exp_lat, lat, bsy;
        ref_alu(op, a, b, exp_r, exp_ovf, exp_lat);
        check({tag, ".in_ready"}, W'(in_ready), 32'd1);
        alu_op = op; oprd1 = a; oprd2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; oprd1 = $urandom; oprd2 = $urandom; alu_op = 4'($urandom);
        lat = 1; bsy = 0;
        while (!out_valid && lat < 200) begin
            if (busy) bsy++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, W'(lat), W'(exp_lat));
        check({tag, ".busy_cycles"}, W'(bsy), W'(exp_lat - 1));
        check({tag, ".result"}, result, exp_r);
        check({tag, ".zero"}, W'(zero), W'(exp_r == '0));
        check({tag, ".overflow"}, W'(overflow), W'(exp_ovf));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; oprd1 = $urandom; alu_op = 4'b0010;
            @(posedge clk); #1;
            check({tag, ".hold_result"}, result, exp_r);
            check({tag, ".hold_in_ready"}, W'(in_ready), 32'd0);
            check({tag, ".hold_out_valid"}, W'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".released"}, W'({out_valid, in_ready}), 32'd1);
    endtask

    initial begin
        logic [3:0]   rop;
        logic [W-1:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        oprd1 = '0; oprd2 = '0; alu_op = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset.in_ready",  W'(in_ready),  32'd1);
        check("reset.out_valid", W'(out_valid), 32'd0);
        check("reset.busy",      W'(busy),      32'd0);
        check("reset.result",    result,        32'd0);
        check("reset.zero",      W'(zero),      32'd0);
        check("reset.overflow",  W'(overflow),  32'd0);

        run_op("add_ovf",  4'b0010, 32'h7FFF_FFFF, 32'd1, 0);
        run_op("sub_zero", 4'b0110, 32'd5, 32'd5, 0);
        run_op("sub_ovf",  4'b0110, 32'h8000_0000, 32'd1, 0);
        run_op("slt",      4'b0111, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("sltu",     4'b1001, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("sra",      4'b0101, 32'h8000_0000, 32'h24, 0);
        run_op("sll",      4'b0011, 32'd1, 32'd31, 0);
        run_op("mul",      4'b1010, 32'hFFFF_FFFF, 32'd2, 0);
        run_op("mulhu",    4'b1011, 32'hFFFF_FFFF, 32'd2, 0);
        run_op("divu",     4'b1110, 32'd100, 32'd7, 0);
        run_op("remu",     4'b1111, 32'd100, 32'd7, 0);
        run_op("divu_z",   4'b1110, 32'd9, 32'd0, 0);
        run_op("remu_z",   4'b1111, 32'd9, 32'd0, 0);
        run_op("undef",    4'b1101, 32'h1234_5678, 32'd3, 0);
        run_op("hold",     4'b1000, 32'hA5A5_0F0F, 32'h0FF0_FFFF, 5);

        // Reset while an iterative op is in flight.
        alu_op = 4'b1010; oprd1 = 32'd7; oprd2 = 32'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("rst_busy.pre", W'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_busy.out_valid", W'(out_valid), 32'd0);
        check("rst_busy.in_ready",  W'(in_ready),  32'd1);
        check("rst_busy.busy",      W'(busy),      32'd0);
        check("rst_busy.result",    result,        32'd0);
        run_op("after_rst", 4'b0010, 32'd40, 32'd2, 0);

        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = $urandom_range(1, 20);
                default: rb = $urandom;
            endcase
            if (i % 5 == 0) ra = (i % 10 == 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
            run_op($sformatf("rand%0d_op%b", i, rop), rop, ra, rb, i % 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
